// File: rtl/ram_if_master_if.sv
// Ram_if memory port: client drives the access, slave returns data and stall.
// data_r is valid the cycle after an access is taken (en=1, delay=0).
interface Ram_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    localparam int BYTE_COUNT = (DATA_WIDTH + 7) / 8;

    logic                  en;
    logic                  we;
    logic [BYTE_COUNT-1:0] be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_w;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  delay;

    modport client (
        output en, we, be, addr, data_w,
        input  data_r, delay
    );

    modport slave (
        input  en, we, be, addr, data_w,
        output data_r, delay
    );
endinterface

// File: rtl/ram_if_master.sv
// Ram_if initiator: request stream in, registered accesses out,
// read data returned in order through a credit-guarded response FIFO.
module ram_if_master #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RSP_DEPTH  = 4,
    localparam int BYTE_COUNT = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [BYTE_COUNT-1:0] req_be,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy,
    Ram_if.client                 intf
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    logic                  rst_sync_q;
    logic                  en_q, en_d;
    logic                  we_q, we_d;
    logic [BYTE_COUNT-1:0] be_q, be_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_w_q, data_w_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];

    logic          slot_free;
    logic          credit;
    logic          accept;
    logic          push;
    logic          pop;
    logic [SW-1:0] used;

    // Handshake: slot availability, read credit and accept decision.
    always_comb begin
        slot_free = !en_q || !intf.delay;
        used      = SW'(count_q) + SW'(en_q && !we_q) + SW'(rd_pend_q);
        credit    = (used + SW'(1)) <= SW'(RSP_DEPTH);
        req_ready = slot_free && (req_we || credit) && rst_sync_q;
        accept    = req_valid && req_ready;
        push      = rd_pend_q;
        pop       = (count_q != '0) && rsp_ready;
    end

    // Access register next state; held while memory stalls.
    always_comb begin
        en_d     = en_q;
        we_d     = we_q;
        be_d     = be_q;
        addr_d   = addr_q;
        data_w_d = data_w_q;
        if (accept) begin
            en_d     = 1'b1;
            we_d     = req_we;
            be_d     = req_we ? req_be : '1;
            addr_d   = req_addr;
            data_w_d = req_data;
        end else if (slot_free) begin
            en_d = 1'b0;
        end
        rd_pend_d = en_q && !we_q && !intf.delay;
    end

    // Response FIFO pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Control state; reset drops any in-flight access or read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 1'b0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            data_w_q   <= '0;
            rd_pend_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            rst_sync_q <= 1'b1;
            en_q       <= en_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            data_w_q   <= data_w_d;
            rd_pend_q  <= rd_pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage captures data_r the cycle after a read is taken.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= intf.data_r;
        end
    end

    assign intf.en     = en_q;
    assign intf.we     = we_q;
    assign intf.be     = be_q;
    assign intf.addr   = addr_q;
    assign intf.data_w = data_w_q;

    assign rsp_valid = count_q != '0;
    assign rsp_data  = rsp_valid ? mem_q[rd_ptr_q] : '0;
    assign busy      = en_q || rd_pend_q || rsp_valid;
endmodule

// File: tb/tb_ram_if_master.sv
// Bench for ram_if_master: behavioural memory slave, shadow-memory
// reference model with an in-order expected-read queue, directed + random.
module tb_ram_if_master;
    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [9:0]  req_addr;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;

    Ram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) intf ();

    ram_if_master #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(32),
        .RSP_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_be   (req_be),
        .req_addr (req_addr),
        .req_data (req_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .busy     (busy),
        .intf     (intf)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory slave: takes access on en && !delay, read data next cycle.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (intf.en && !intf.delay) begin
            if (intf.we) begin
                for (int b = 0; b < 4; b++)
                    if (intf.be[b])
                        mem[intf.addr][b*8 +: 8] <= intf.data_w[b*8 +: 8];
            end else begin
                intf.data_r <= mem[intf.addr];
            end
        end
    end

    // Reference model: shadow memory updated in acceptance order.
    logic [31:0] sh [0:1023];
    logic [31:0] exp_q [$];
    int          acc_q [$];
    int          acc_cyc [$];
    int          pop_cyc [$];
    int          n_acc = 0;
    int          n_pop = 0;
    bit          head_seen = 0;
    bit          lat_en = 0;
    int          lat_exp = 0;
    logic [31:0] last_rsp = '0;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            acc_q.delete();
            head_seen = 0;
        end else begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    if (!head_seen) begin
                        head_seen = 1;
                        if (lat_en)
                            check("latency", 64'(cyc - acc_q[0]), 64'(lat_exp));
                    end
                    if (rsp_ready) begin
                        check("rsp_data", 64'(rsp_data), 64'(exp_q[0]));
                        last_rsp = rsp_data;
                        pop_cyc.push_back(cyc);
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        head_seen = 0;
                        n_pop++;
                    end
                end
            end
            if (req_valid && req_ready) begin
                n_acc++;
                acc_cyc.push_back(cyc);
                if (req_we) begin
                    for (int b = 0; b < 4; b++)
                        if (req_be[b])
                            sh[req_addr][b*8 +: 8] = req_data[b*8 +: 8];
                end else begin
                    exp_q.push_back(sh[req_addr]);
                    acc_q.push_back(cyc);
                end
            end
        end
    end

    // Offer one request; returns one step after the accepting edge.
    task automatic send(input logic we, input logic [3:0] be,
                        input logic [9:0] addr, input logic [31:0] data);
        bit ok;
        ok = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_data  = data;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        check("drain_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    int  b_acc, b_pop;
    bit  rand_done;

    initial begin
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_be      = '0;
        req_addr    = '0;
        req_data    = '0;
        rsp_ready   = 1'b1;
        intf.delay  = 1'b0;
        rand_done   = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_en", 64'(intf.en), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_rst", 64'(req_ready), 64'd1);

        // single write then read
        send(1'b1, 4'hF, 10'h005, 32'hDEADBEEF);
        check("wr_en", 64'(intf.en), 64'd1);
        check("wr_we", 64'(intf.we), 64'd1);
        check("wr_addr", 64'(intf.addr), 64'h005);
        check("wr_data", 64'(intf.data_w), 64'hDEADBEEF);
        @(posedge clk);
        #1;
        check("wr_en_pulse", 64'(intf.en), 64'd0);
        lat_en  = 1;
        lat_exp = 3;
        send(1'b0, 4'h0, 10'h005, 32'h0);
        check("rd_en", 64'(intf.en), 64'd1);
        check("rd_be_ones", 64'(intf.be), 64'hF);
        drain();
        lat_en = 0;
        check("wr_rd_data", 64'(last_rsp), 64'hDEADBEEF);

        // byte mask
        send(1'b1, 4'hF, 10'h007, 32'h11223344);
        send(1'b1, 4'b0101, 10'h007, 32'hAABBCCDD);
        send(1'b0, 4'hF, 10'h007, 32'h0);
        drain();
        check("bytemask", 64'(last_rsp), 64'h11BB33DD);

        // streaming
        for (int i = 0; i < 16; i++) send(1'b1, 4'hF, 10'(i), 32'(i * 3));
        drain();
        b_acc = acc_cyc.size();
        b_pop = pop_cyc.size();
        for (int i = 0; i < 16; i++) send(1'b0, 4'hF, 10'(i), 32'h0);
        drain();
        check("stream_pops", 64'(pop_cyc.size() - b_pop), 64'd16);
        check("stream_acc_span",
              64'(acc_cyc[b_acc + 15] - acc_cyc[b_acc]), 64'd15);
        check("stream_rsp_span",
              64'(pop_cyc[b_pop + 15] - pop_cyc[b_pop]), 64'd15);
        check("stream_last", 64'(last_rsp), 64'd45);

        // backpressure
        rsp_ready = 1'b0;
        b_acc = n_acc;
        b_pop = n_pop;
        fork
            begin
                for (int i = 0; i < 8; i++) send(1'b0, 4'hF, 10'(8 + i), 32'h0);
            end
            begin
                repeat (20) @(negedge clk);
                check("bp_accepts", 64'(n_acc - b_acc), 64'd4);
                check("bp_valid", 64'(rsp_valid), 64'd1);
                check("bp_head", 64'(rsp_data), 64'd24);
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        drain();
        check("bp_delivered", 64'(n_pop - b_pop), 64'd8);

        // delay stall
        send(1'b1, 4'hF, 10'h3FF, 32'hCAFEF00D);
        drain();
        lat_en  = 1;
        lat_exp = 6;
        send(1'b0, 4'hF, 10'h3FF, 32'h0);
        intf.delay = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_en", 64'(intf.en), 64'd1);
            check("stall_addr", 64'(intf.addr), 64'h3FF);
            check("stall_we", 64'(intf.we), 64'd0);
            check("stall_be", 64'(intf.be), 64'hF);
            check("stall_rdy", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        intf.delay = 1'b0;
        drain();
        lat_en = 0;
        check("stall_data", 64'(last_rsp), 64'hCAFEF00D);

        // mid-operation reset
        rsp_ready = 1'b0;
        send(1'b0, 4'hF, 10'd1, 32'h0);
        send(1'b0, 4'hF, 10'd2, 32'h0);
        send(1'b0, 4'hF, 10'd3, 32'h0);
        reset = 1'b0;
        #1;
        check("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mrst_rsp_data", 64'(rsp_data), 64'd0);
        check("mrst_req_ready", 64'(req_ready), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_en", 64'(intf.en), 64'd0);
        check("mrst_be", 64'(intf.be), 64'd0);
        check("mrst_addr", 64'(intf.addr), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        rsp_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("mrst_no_rsp", 64'(rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(1'b0, 4'hF, 10'd9, 32'h0);
        drain();
        check("mrst_new_rd", 64'(last_rsp), 64'd27);

        // randomized traffic
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end else begin
                        send(1'($urandom_range(0, 1)), 4'($urandom),
                             10'($urandom_range(0, 15)), $urandom);
                    end
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    intf.delay = ($urandom_range(0, 3) == 0);
                    rsp_ready  = ($urandom_range(0, 3) != 0);
                end
            end
        join
        intf.delay = 1'b0;
        rsp_ready  = 1'b1;
        drain();
        check("end_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ram_if_master.md
# ram_if_master

Initiator side of the `Ram_if` memory port. It converts a valid/ready request stream (reads and byte-masked writes) into `Ram_if` accesses and obeys the `delay` stall. Read data is returned in order through a small response FIFO. It sits between a core or loader and an `L1_memory` port, and sustains one access per cycle when `delay` is low.

## Interface
- `ADDR_WIDTH`, 10: word address width of `Ram_if`.
- `DATA_WIDTH`, 32: data word width.
- `RSP_DEPTH`, 4: response FIFO entries, power of two, ≥ 4.
- `BYTE_COUNT`, derived as ceil(`DATA_WIDTH`/8): byte-enable width.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on edges where `req_valid` && `req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_be`  in  `BYTE_COUNT`  byte enables; ignored for reads.
- `req_addr`  in  `ADDR_WIDTH`  word address.
- `req_data`  in  `DATA_WIDTH`  write data.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes `rsp_data` on edges where both are high.
- `rsp_data`  out  `DATA_WIDTH`  read data, in request order.
- `busy`  out  1  access on `Ram_if`, read in flight, or FIFO non-empty.
- `intf`  `Ram_if.client`  drives `en`, `we`, `be`, `addr`, `data_w`; samples `data_r`, `delay`.

## Operation
- **Access register (AR):** holds `en`, `we`, `be`, `addr`, `data_w`; drives `intf` directly from flops, with no combinational path from `req_*`.
- **Access acceptance:**
  - An access is taken by memory on an edge where `en`=1 and `delay`=0.
  - While `delay`=1 the AR holds all fields unchanged.
- **Slot free:** `en`=0, or `delay`=0 this cycle.
- **Credit:** `fifo_count` + (`en`&&!`we`) + `rd_pend` + 1 ≤ `RSP_DEPTH`. Writes need no credit.
- **`req_ready`:** slot free && (`req_we` || credit) && reset deasserted. Combinational from `delay`, `req_we`, and state.
- **On accept:** AR loads the request, with `en`=1. If the slot is free and there is no accept, `en`=0.
- **`be` on reads:** driven as all-ones.
- **`rd_pend`:** set at the edge a read is taken by memory, otherwise cleared.
- **Read capture:** in a cycle with `rd_pend`=1, `data_r` is pushed into the FIFO at the end of that cycle, unconditionally. Credit guarantees space.
- **FIFO:**
  - Circular, with `log2(RSP_DEPTH)`-bit read and write pointers plus a count.
  - Push and pop in the same cycle leave count unchanged.
  - `rsp_valid` = count ≠ 0; `rsp_data` = head entry, registered storage.
- **Writes:** produce no response.
- **Ordering:** reads and writes are issued strictly in acceptance order. A read after a write to the same address returns the new data.
- **Reset asserted (async):**
  - `en`, `we`, `be`, `addr`, `data_w` = 0; `rd_pend` = 0.
  - FIFO empty, pointers = 0.
  - `rsp_valid` = 0, `req_ready` = 0, `busy` = 0.
  - An access or read in flight is discarded and gives no response.
  - Reset release is synchronised internally. `req_ready` may assert from the first edge after release.

## Timing
- **Read (`delay`=0):** accept edge E0 → `en`=1 in C1 → `data_r` valid in C2 → pushed at E2 → `rsp_valid` in C3. Latency is 3 cycles from accept to `rsp_valid`.
- **Write:** `en`=1 in C1 only; `busy` drops in C2 if nothing else is pending.
- **Stall:** each cycle with `en`=1 and `delay`=1 adds one cycle of latency. `req_ready` is 0 during those cycles.
- **Throughput:** one access per cycle with `delay`=0 and `rsp_ready`=1. `RSP_DEPTH`=4 sustains back-to-back reads without bubbles.
- **Backpressure:** with `rsp_ready`=0, reads stop being accepted once credit is exhausted. Exactly `RSP_DEPTH` reads complete; no data is lost or overwritten. Writes are still accepted.
- **Wrap-around:** FIFO pointers wrap modulo `RSP_DEPTH`. `req_addr` is passed through unmodified.

## Test plan
- **Single write then read:** write 0xDEADBEEF to addr 0x005 with be=1111, then read 0x005. `en` pulses in C1 of each access; read `rsp_data` = 0xDEADBEEF exactly 3 cycles after its accept.
- **Byte mask:** write 0x11223344 (be=1111), then 0xAABBCCDD with be=0101, then read. `rsp_data` = 0x11BB33DD.
- **Streaming:** 16 back-to-back reads of addr 0..15 (preloaded addr*3), `rsp_ready`=1, `delay`=0. One accept per cycle; responses 0,3,...,45 in order on 16 consecutive cycles.
- **Backpressure:** `rsp_ready`=0 with 8 reads offered. Exactly 4 accepted and `rsp_valid` held with head = first read. Release `rsp_ready` → all 8 delivered in order, no duplicates.
- **Delay stall:** force `delay`=1 for 3 cycles during a read to 0x3FF. AR fields stay stable, `req_ready`=0, and response latency is 6 cycles.
- **Mid-operation reset:** assert `reset` low while 2 reads are in flight and 1 is in the FIFO. All outputs go to 0 immediately. After release `rsp_valid` stays 0 until a new read is accepted, and that read returns correct data.
